// File: rtl/sect283k1_pm_arb.sv
// Round-robin arbiter sharing one sect283k1 point multiplier between two requesters,
// with a watchdog that aborts a multiplication which never reports completion.
module sect283k1_pm_arb #(
    parameter int unsigned   CW      = 24,
    parameter logic [CW-1:0] TIMEOUT = 24'd4000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         req0,
    input  logic         req1,
    input  logic [282:0] d0,
    input  logic [282:0] d1,
    output logic         ack0,
    output logic         ack1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic         busy,
    output logic [282:0] x,
    output logic [282:0] y,
    output logic         pm_clr,
    output logic         pm_start,
    output logic [282:0] pm_d,
    input  logic         pm_done,
    input  logic [282:0] pm_x,
    input  logic [282:0] pm_y
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [CW-1:0] WDOG_LAST = TIMEOUT - 1'b1;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [CW-1:0]  wdog_q, wdog_d;
    logic           pm_done_q;
    logic [282:0]   x_q, x_d;
    logic [282:0]   y_q, y_d;
    logic [282:0]   pm_d_q, pm_d_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;
    logic           err_q, err_d;
    logic           pm_clr_q, pm_clr_d;
    logic           pm_start_q, pm_start_d;
    logic           busy_q;

    logic           grant_sel;
    logic           complete;

    // On a tie the port that did not win last time is chosen.
    assign grant_sel = (req0 & req1) ? ~last_grant_q : req1;
    // Only a fresh rising edge counts, so a stale level from a previous run is ignored.
    assign complete  = pm_done & ~pm_done_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wdog_d       = wdog_q;
        x_d          = x_q;
        y_d          = y_q;
        pm_d_d       = pm_d_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err_d        = 1'b0;
        pm_clr_d     = 1'b0;
        pm_start_d   = 1'b0;

        if (clr) begin
            state_d      = IDLE;
            last_grant_d = 1'b1;
            wdog_d       = '0;
            pm_clr_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        pm_d_d       = grant_sel ? d1 : d0;
                        ack0_d       = ~grant_sel;
                        ack1_d       = grant_sel;
                        pm_start_d   = 1'b1;
                        wdog_d       = '0;
                        owner_d      = grant_sel;
                        last_grant_d = grant_sel;
                        state_d      = WAIT;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        x_d     = pm_x;
                        y_d     = pm_y;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                        state_d = IDLE;
                    end else if (wdog_q == WDOG_LAST) begin
                        err_d    = 1'b1;
                        pm_clr_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
            pm_done_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pm_d_q       <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            pm_clr_q     <= 1'b0;
            pm_start_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wdog_q       <= wdog_d;
            pm_done_q    <= pm_done;
            x_q          <= x_d;
            y_q          <= y_d;
            pm_d_q       <= pm_d_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            pm_clr_q     <= pm_clr_d;
            pm_start_q   <= pm_start_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign x        = x_q;
    assign y        = y_q;
    assign pm_clr   = pm_clr_q;
    assign pm_start = pm_start_q;
    assign pm_d     = pm_d_q;

endmodule

// File: tb/tb_sect283k1_pm_arb.sv
// Directed bench for sect283k1_pm_arb; the point multiplier is modelled by driving pm_done/pm_x/pm_y.
module tb_sect283k1_pm_arb;

    logic         clk = 1'b0;
    logic         rst_n, clr, req0, req1, pm_done;
    logic [282:0] d0, d1, pm_x, pm_y;
    logic         ack0, ack1, done0, done1, err, busy, pm_clr, pm_start;
    logic [282:0] x, y, pm_d;

    int vec_cnt = 0;
    int err_cnt = 0;

    sect283k1_pm_arb #(.CW(24), .TIMEOUT(24'd16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req0(req0), .req1(req1),
        .d0(d0), .d1(d1), .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .err(err), .busy(busy), .x(x), .y(y), .pm_clr(pm_clr), .pm_start(pm_start),
        .pm_d(pm_d), .pm_done(pm_done), .pm_x(pm_x), .pm_y(pm_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; req0 = 1'b0; req1 = 1'b0; pm_done = 1'b0;
        d0 = '0; d1 = '0; pm_x = '0; pm_y = '0;
        repeat (3) tick();
        vec_cnt++; if ({ack0, ack1, done0, done1, err, pm_clr, pm_start, busy} !== 8'h00) begin err_cnt++; $display("FAIL reset_pulses: got %b want 00000000", {ack0, ack1, done0, done1, err, pm_clr, pm_start, busy}); end
        vec_cnt++; if ((x | y | pm_d) !== 283'h0) begin err_cnt++; $display("FAIL reset_data: got x=%h y=%h pm_d=%h want 0", x, y, pm_d); end
        rst_n = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_single();
        req0 = 1'b1; d0 = 283'h5;
        tick();
        vec_cnt++; if ({ack0, ack1, pm_start, busy} !== 4'b1011) begin err_cnt++; $display("FAIL single_grant: got ack0,ack1,start,busy=%b want 1011", {ack0, ack1, pm_start, busy}); end
        vec_cnt++; if (pm_d !== 283'h5) begin err_cnt++; $display("FAIL single_pm_d: got %h want 5", pm_d); end
        req0 = 1'b0;
        tick();
        vec_cnt++; if ({ack0, pm_start} !== 2'b00) begin err_cnt++; $display("FAIL single_pulse_width: got ack0,start=%b want 00", {ack0, pm_start}); end
        pm_done = 1'b1; pm_x = 283'hA; pm_y = 283'hB;
        tick();
        vec_cnt++; if ({done0, done1, busy} !== 3'b100) begin err_cnt++; $display("FAIL single_done: got done0,done1,busy=%b want 100", {done0, done1, busy}); end
        vec_cnt++; if (x !== 283'hA || y !== 283'hB) begin err_cnt++; $display("FAIL single_xy: got x=%h y=%h want A B", x, y); end
        pm_done = 1'b0;
        tick();
        vec_cnt++; if (done0 !== 1'b0) begin err_cnt++; $display("FAIL single_done_width: got %b want 0", done0); end
        $display("single: d0=5 -> x=A y=B");
    endtask

    task automatic test_tie();
        req0 = 1'b1; req1 = 1'b1; d0 = 283'h1; d1 = 283'h2;
        do_reset();
        tick();
        vec_cnt++; if ({ack0, ack1} !== 2'b10 || pm_d !== 283'h1) begin err_cnt++; $display("FAIL tie_first: got ack0,ack1=%b pm_d=%h want 10 1", {ack0, ack1}, pm_d); end
        req0 = 1'b0;
        pm_done = 1'b1; pm_x = 283'h11; pm_y = 283'h12;
        tick();
        vec_cnt++; if ({done0, done1} !== 2'b10) begin err_cnt++; $display("FAIL tie_done0: got %b want 10", {done0, done1}); end
        pm_done = 1'b0;
        tick();
        vec_cnt++; if ({ack0, ack1} !== 2'b01 || pm_d !== 283'h2) begin err_cnt++; $display("FAIL tie_second: got ack0,ack1=%b pm_d=%h want 01 2", {ack0, ack1}, pm_d); end
        req1 = 1'b0;
        pm_done = 1'b1; pm_x = 283'h21; pm_y = 283'h22;
        tick();
        vec_cnt++; if ({done0, done1} !== 2'b01 || x !== 283'h21) begin err_cnt++; $display("FAIL tie_done1: got done=%b x=%h want 01 21", {done0, done1}, x); end
        pm_done = 1'b0;
        tick();
        $display("tie: grants port0 then port1");
    endtask

    task automatic test_fairness();
        req0 = 1'b1; req1 = 1'b1; d0 = 283'h10; d1 = 283'h20;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [1:0]   exp_ack;
            logic [282:0] exp_d;
            exp_ack = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_d   = (i % 2 == 0) ? 283'h10 : 283'h20;
            tick();
            vec_cnt++; if ({ack0, ack1} !== exp_ack || pm_d !== exp_d) begin err_cnt++; $display("FAIL fair_grant%0d: got ack=%b pm_d=%h want %b %h", i, {ack0, ack1}, pm_d, exp_ack, exp_d); end
            pm_done = 1'b1; pm_x = 283'h100 + 283'(i); pm_y = 283'h200;
            tick();
            vec_cnt++; if ({done0, done1} !== exp_ack || x !== 283'h100 + 283'(i)) begin err_cnt++; $display("FAIL fair_done%0d: got done=%b x=%h want %b %h", i, {done0, done1}, x, exp_ack, 283'h100 + 283'(i)); end
            pm_done = 1'b0;
            $display("fairness: op %0d granted port %0d", i, i % 2);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_level_done();
        pm_done = 1'b1; pm_x = 283'h88; pm_y = 283'h89;
        req1 = 1'b1; d1 = 283'h77;
        tick();
        vec_cnt++; if (ack1 !== 1'b1 || pm_d !== 283'h77) begin err_cnt++; $display("FAIL level_grant: got ack1=%b pm_d=%h want 1 77", ack1, pm_d); end
        req1 = 1'b0;
        tick();
        vec_cnt++; if ({done1, busy} !== 2'b01) begin err_cnt++; $display("FAIL level_no_done: got done1,busy=%b want 01", {done1, busy}); end
        pm_done = 1'b0;
        tick();
        pm_done = 1'b1;
        tick();
        vec_cnt++; if (done1 !== 1'b1 || x !== 283'h88) begin err_cnt++; $display("FAIL level_done: got done1=%b x=%h want 1 88", done1, x); end
        pm_done = 1'b0;
        tick();
        $display("level_done: stale pm_done ignored");
    endtask

    task automatic test_race();
        req0 = 1'b1; d0 = 283'h44;
        tick();
        req0 = 1'b0; pm_x = 283'h55; pm_y = 283'h66;
        repeat (15) tick();
        vec_cnt++; if ({err, done0} !== 2'b00) begin err_cnt++; $display("FAIL race_early: got err,done0=%b want 00", {err, done0}); end
        pm_done = 1'b1;
        tick();
        vec_cnt++; if ({done0, err, pm_clr} !== 3'b100 || x !== 283'h55) begin err_cnt++; $display("FAIL race_completion_wins: got done0,err,pm_clr=%b x=%h want 100 55", {done0, err, pm_clr}, x); end
        pm_done = 1'b0;
        tick();
        $display("race: completion beats watchdog");
    endtask

    task automatic test_timeout();
        req0 = 1'b1; d0 = 283'h7;
        tick();
        req0 = 1'b0; pm_x = 283'hDEAD; pm_y = 283'hBEEF;
        repeat (15) tick();
        vec_cnt++; if ({err, pm_clr, busy} !== 3'b001) begin err_cnt++; $display("FAIL timeout_early: got err,pm_clr,busy=%b want 001", {err, pm_clr, busy}); end
        tick();
        vec_cnt++; if ({err, pm_clr, done0, done1, busy} !== 5'b11000) begin err_cnt++; $display("FAIL timeout_abort: got err,pm_clr,done0,done1,busy=%b want 11000", {err, pm_clr, done0, done1, busy}); end
        vec_cnt++; if (x !== 283'h55 || y !== 283'h66) begin err_cnt++; $display("FAIL timeout_xy_held: got x=%h y=%h want 55 66", x, y); end
        tick();
        vec_cnt++; if ({err, pm_clr} !== 2'b00) begin err_cnt++; $display("FAIL timeout_pulse_width: got %b want 00", {err, pm_clr}); end
        $display("timeout: err after 16 WAIT cycles");
    endtask

    task automatic test_abort();
        req0 = 1'b1; d0 = 283'h9;
        tick();
        req0 = 1'b0;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vec_cnt++; if ({pm_clr, busy, done0, err} !== 4'b1000 || pm_d !== 283'h9) begin err_cnt++; $display("FAIL abort_clr: got pm_clr,busy,done0,err=%b pm_d=%h want 1000 9", {pm_clr, busy, done0, err}, pm_d); end
        pm_done = 1'b1; pm_x = 283'h31;
        tick();
        vec_cnt++; if ({done0, done1, pm_clr} !== 3'b000 || x !== 283'h55) begin err_cnt++; $display("FAIL abort_late_done: got done0,done1,pm_clr=%b x=%h want 000 55", {done0, done1, pm_clr}, x); end
        pm_done = 1'b0;
        req0 = 1'b1; req1 = 1'b1; d0 = 283'h33; d1 = 283'h34;
        tick();
        vec_cnt++; if ({ack0, ack1} !== 2'b10 || pm_d !== 283'h33) begin err_cnt++; $display("FAIL abort_regrant: got ack=%b pm_d=%h want 10 33", {ack0, ack1}, pm_d); end
        req0 = 1'b0; req1 = 1'b0;
        pm_done = 1'b1; pm_x = 283'h99; pm_y = 283'h9A;
        tick();
        vec_cnt++; if (done0 !== 1'b1 || x !== 283'h99) begin err_cnt++; $display("FAIL abort_next_done: got done0=%b x=%h want 1 99", done0, x); end
        pm_done = 1'b0;
        tick();
        $display("abort: clr drops op, next grant normal");
    endtask

    task automatic test_clr_priority();
        req1 = 1'b1; d1 = 283'h3C; clr = 1'b1;
        tick();
        clr = 1'b0;
        vec_cnt++; if ({ack1, pm_start, pm_clr, busy} !== 4'b0010) begin err_cnt++; $display("FAIL clrpri_grant: got ack1,start,pm_clr,busy=%b want 0010", {ack1, pm_start, pm_clr, busy}); end
        tick();
        vec_cnt++; if (ack1 !== 1'b1 || pm_d !== 283'h3C) begin err_cnt++; $display("FAIL clrpri_after: got ack1=%b pm_d=%h want 1 3c", ack1, pm_d); end
        req1 = 1'b0;
        pm_done = 1'b1; pm_x = 283'h4D; clr = 1'b1;
        tick();
        clr = 1'b0; pm_done = 1'b0;
        vec_cnt++; if ({done1, pm_clr, busy} !== 3'b010 || x !== 283'h99) begin err_cnt++; $display("FAIL clrpri_done: got done1,pm_clr,busy=%b x=%h want 010 99", {done1, pm_clr, busy}, x); end
        tick();
        $display("clr_priority: clr beats grant and completion");
    endtask

    task automatic test_async_reset();
        req0 = 1'b1; d0 = 283'h5A;
        tick();
        req0 = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if ({ack0, done0, done1, err, pm_clr, pm_start, busy} !== 7'h00) begin err_cnt++; $display("FAIL async_pulses: got %b want 0000000", {ack0, done0, done1, err, pm_clr, pm_start, busy}); end
        vec_cnt++; if ((x | y | pm_d) !== 283'h0) begin err_cnt++; $display("FAIL async_data: got x=%h pm_d=%h want 0", x, pm_d); end
        rst_n = 1'b1;
        tick();
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL async_idle: got busy=%b want 0", busy); end
        $display("async_reset: mid-WAIT reset clears outputs");
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_level_done();
        test_race();
        test_timeout();
        test_abort();
        test_clr_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
